// File: rtl/evb_pkg.sv
// evb_pkg: shared FSM state encoding, response status codes and a ceil-log2 sizing helper for the EVB arbiter
package evb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_ABORT, S_RESP} state_t;
  localparam logic [31:0] STATUS_RESET   = 32'hFFFF_FFFF;
  localparam logic [31:0] STATUS_TIMEOUT = 32'hFFFF_FFFE;
  localparam logic [31:0] STATUS_BADARG  = 32'hFFFF_FFFD;
  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/evb_rr_pick.sv
// evb_rr_pick: combinational round-robin first-one finder; in req, rr_ptr; out grant_idx (first set bit at/after rr_ptr, wrapping), any
module evb_rr_pick import evb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [log2(NUM_REQ)-1:0]   rr_ptr,
  output logic [log2(NUM_REQ)-1:0]   grant_idx,
  output logic                       any
);
  localparam int IW = log2(NUM_REQ);
  always_comb begin
    any = |req;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [IW-1:0] j;
      j = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[j]) grant_idx = j;
    end
  end
endmodule

// File: rtl/evb_arbiter.sv
// evb_arbiter: round-robin share of one EVB engine; in clk, rst (sync active-low), req/req_A/req_b/req_x, done_evb/evb_result/evb_status; out ack, rsp_valid/rsp_result/rsp_status, busy, start_evb, rst_instr, A/b/x_b
module evb_arbiter import evb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [3*NUM_REQ-1:0]    req_A,
  input  logic [5*NUM_REQ-1:0]    req_b,
  input  logic [16*NUM_REQ-1:0]   req_x,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_result,
  output logic [31:0]             rsp_status,
  output logic                    busy,
  output logic                    start_evb,
  output logic                    rst_instr,
  output logic [2:0]              A,
  output logic [4:0]              b,
  output logic [15:0]             x_b,
  input  logic                    done_evb,
  input  logic [31:0]             evb_result,
  input  logic [31:0]             evb_status
);
  localparam int IW = log2(NUM_REQ);
  localparam int TW = log2(TIMEOUT);
  state_t state, nxt;
  logic [IW-1:0] idx, rr_ptr, pick;
  logic [TW-1:0] timer;
  logic any;
  logic [NUM_REQ-1:0] sel;
  logic [NUM_REQ-1:0][2:0] a_v;
  logic [NUM_REQ-1:0][4:0] b_v;
  logic [NUM_REQ-1:0][15:0] x_v;
  evb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .grant_idx(pick),
    .any(any)
  );
  always_comb begin
    a_v = req_A;
    b_v = req_b;
    x_v = req_x;
    sel = NUM_REQ'(1) << idx;
    nxt = state == S_IDLE  ? (any ? S_GRANT : S_IDLE) :
          state == S_GRANT ? (b == '0 ? S_RESP : S_ISSUE) :
          state == S_ISSUE ? S_WAIT :
          state == S_WAIT  ? (done_evb ? S_RESP : timer == TW'(TIMEOUT - 1) ? S_ABORT : S_WAIT) :
          state == S_ABORT ? S_RESP : S_IDLE;
    ack = state == S_GRANT ? sel : '0;
    rsp_valid = state == S_RESP ? sel : '0;
    busy = state != S_IDLE;
    start_evb = state == S_ISSUE;
    rst_instr = state != S_ABORT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      idx <= '0;
      rr_ptr <= '0;
      timer <= '0;
      A <= '0;
      b <= '0;
      x_b <= '0;
      rsp_result <= '0;
      rsp_status <= STATUS_RESET;
    end else begin
      state <= nxt;
      timer <= state == S_WAIT ? timer + 1'b1 : '0;
      if (state == S_IDLE && any) begin
        idx <= pick;
        A <= a_v[pick];
        b <= b_v[pick];
        x_b <= x_v[pick];
      end
      if (state == S_GRANT && b == '0) begin
        rsp_result <= '0;
        rsp_status <= STATUS_BADARG;
      end
      if (state == S_WAIT && done_evb) begin
        rsp_result <= evb_result;
        rsp_status <= evb_status;
      end
      if (state == S_ABORT) begin
        rsp_result <= '0;
        rsp_status <= STATUS_TIMEOUT;
      end
      if (state == S_RESP) rr_ptr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
  end
endmodule
